// File: rtl/motoro3_pkg.sv
// Shared types and helpers for the motoro3 PWM capture path.
package motoro3_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} cap_state_t;

  localparam int unsigned CNT_W_DEF = 16;

  // Increment acc by inc, holding at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] acc, input logic inc,
                                          input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (inc && (acc < max_v)) ? acc + 32'd1 : acc;
  endfunction

endpackage

// File: rtl/motoro3_pwm_deglitch.sv
// PWM input conditioning: 2-flop synchronizer plus an integrator filter that is
// compiled in only when M3_PWM_CAP_DEGLITCH_EN is defined.
module motoro3_pwm_deglitch #(
  parameter int unsigned GLITCH_LEN = 3
) (
  input  logic clk,
  input  logic nRst,
  input  logic pwmIn,
  output logic lvl
);

  logic sync1, sync2;

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwmIn;
      sync2 <= sync1;
    end
  end

`ifdef M3_PWM_CAP_DEGLITCH_EN
  localparam int unsigned RUN_W = $clog2(GLITCH_LEN + 1);

  logic [RUN_W-1:0] run;

  // run counts consecutive samples disagreeing with lvl; any agreeing sample restarts it
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      run <= '0;
      lvl <= 1'b0;
    end else if (sync2 == lvl) begin
      run <= '0;
    end else if (run == RUN_W'(GLITCH_LEN - 1)) begin
      run <= '0;
      lvl <= sync2;
    end else begin
      run <= run + 1'b1;
    end
  end
`else
  assign lvl = sync2;
`endif

endmodule

// File: rtl/motoro3_pwm_capture.sv
// PWM pulse/period capture with per-commutation-step on-time accounting.
// Optional input deglitch filter selected by M3_PWM_CAP_DEGLITCH_EN.
module motoro3_pwm_capture
  import motoro3_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned TIMEOUT    = 16'hFFFF,
  parameter int unsigned GLITCH_LEN = 3
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             pwmIn,
  input  logic             stepEnd,
  output logic [CNT_W-1:0] capHigh,
  output logic [CNT_W-1:0] capPeriod,
  output logic             capValid,
  output logic [CNT_W-1:0] stepOnSum,
  output logic [7:0]       stepPulses,
  output logic             stepValid,
  output logic             timeout,
  output logic             stuckLevel
);

  logic             lvl, lvl_q, rise;
  cap_state_t       state;
  logic [CNT_W-1:0] hi_cnt, per_cnt, on_acc;
  logic [7:0]       pulse_acc;

  motoro3_pwm_deglitch #(.GLITCH_LEN(GLITCH_LEN)) u_deglitch (
    .clk   (clk),
    .nRst  (nRst),
    .pwmIn (pwmIn),
    .lvl   (lvl)
  );

  assign rise = lvl & ~lvl_q;

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      lvl_q      <= 1'b0;
      hi_cnt     <= '0;
      per_cnt    <= '0;
      capHigh    <= '0;
      capPeriod  <= '0;
      capValid   <= 1'b0;
      timeout    <= 1'b0;
      stuckLevel <= 1'b0;
    end else begin
      lvl_q    <= lvl;
      capValid <= 1'b0;
      timeout  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            hi_cnt  <= CNT_W'(1);
            per_cnt <= CNT_W'(1);
            state   <= HIGH;
          end
        end
        HIGH: begin
          if (per_cnt == CNT_W'(TIMEOUT)) begin
            timeout    <= 1'b1;
            stuckLevel <= lvl;
            state      <= IDLE;
          end else begin
            per_cnt <= per_cnt + 1'b1;
            if (lvl) hi_cnt <= hi_cnt + 1'b1;
            else     state  <= LOW;
          end
        end
        LOW: begin
          // a rise on the timeout cycle still counts as a normal capture
          if (rise) begin
            capHigh   <= hi_cnt;
            capPeriod <= per_cnt;
            capValid  <= 1'b1;
            hi_cnt    <= CNT_W'(1);
            per_cnt   <= CNT_W'(1);
            state     <= HIGH;
          end else if (per_cnt == CNT_W'(TIMEOUT)) begin
            timeout    <= 1'b1;
            stuckLevel <= lvl;
            state      <= IDLE;
          end else begin
            per_cnt <= per_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The stepEnd cycle itself belongs to the step being closed.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      on_acc     <= '0;
      pulse_acc  <= '0;
      stepOnSum  <= '0;
      stepPulses <= '0;
      stepValid  <= 1'b0;
    end else if (stepEnd) begin
      stepOnSum  <= CNT_W'(sat_inc(32'(on_acc), lvl, CNT_W));
      stepPulses <= 8'(sat_inc(32'(pulse_acc), rise, 32'd8));
      stepValid  <= 1'b1;
      on_acc     <= '0;
      pulse_acc  <= '0;
    end else begin
      on_acc     <= CNT_W'(sat_inc(32'(on_acc), lvl, CNT_W));
      pulse_acc  <= 8'(sat_inc(32'(pulse_acc), rise, 32'd8));
      stepValid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_motoro3_pwm_capture.sv
// Self-checking bench for motoro3_pwm_capture: event-level reference model plus
// directed and randomized PWM stimulus. Honours M3_PWM_CAP_DEGLITCH_EN if defined.
module tb_motoro3_pwm_capture;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned TIMEOUT    = 1000;
  localparam int unsigned GLITCH_LEN = 3;
  localparam int unsigned CNT_MAX    = 65535;

  logic             clk = 1'b0;
  logic             nRst = 1'b0;
  logic             pwm_in = 1'b0;
  logic             step_end = 1'b0;
  logic [CNT_W-1:0] cap_high, cap_period, step_on_sum;
  logic [7:0]       step_pulses;
  logic             cap_valid, step_valid, timeout, stuck_level;

  always #50 clk = ~clk;

  motoro3_pwm_capture #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .GLITCH_LEN (GLITCH_LEN)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .pwmIn      (pwm_in),
    .stepEnd    (step_end),
    .capHigh    (cap_high),
    .capPeriod  (cap_period),
    .capValid   (cap_valid),
    .stepOnSum  (step_on_sum),
    .stepPulses (step_pulses),
    .stepValid  (step_valid),
    .timeout    (timeout),
    .stuckLevel (stuck_level)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cnt_cap = 0;
  int unsigned cnt_tmo = 0;

  // Reference model: levels are tracked as edge timestamps, not counters.
  logic        dq[$];
  logic        m_lvl_prev;
  bit          armed;
  int unsigned now, rise_t, fall_t, on_acc, pulse_acc;
  logic [15:0] e_cap_high, e_cap_period, e_on_sum;
  logic [7:0]  e_pulses;
  logic        e_cap_valid, e_step_valid, e_timeout, e_stuck;
`ifdef M3_PWM_CAP_DEGLITCH_EN
  logic        f_lvl;
  logic        s_hist[$];
`endif

  task automatic model_reset();
    dq = '{1'b0, 1'b0};
    m_lvl_prev = 1'b0;
    armed = 0;
    rise_t = 0;
    fall_t = 0;
    on_acc = 0;
    pulse_acc = 0;
    e_cap_high = '0;
    e_cap_period = '0;
    e_on_sum = '0;
    e_pulses = '0;
    e_cap_valid = 1'b0;
    e_step_valid = 1'b0;
    e_timeout = 1'b0;
    e_stuck = 1'b0;
`ifdef M3_PWM_CAP_DEGLITCH_EN
    f_lvl = 1'b0;
    s_hist.delete();
`endif
  endtask

  task automatic model_edge(input logic p, input logic se);
    logic s, lvl, rise;
    bit   all_diff;
    now++;
    s = dq.pop_front();
    dq.push_back(p);
`ifdef M3_PWM_CAP_DEGLITCH_EN
    lvl = f_lvl;
    s_hist.push_back(s);
    if (s_hist.size() > GLITCH_LEN) void'(s_hist.pop_front());
    all_diff = (s_hist.size() == GLITCH_LEN);
    foreach (s_hist[k]) if (s_hist[k] == f_lvl) all_diff = 0;
    if (all_diff) f_lvl = ~f_lvl;
`else
    all_diff = 0;
    lvl = s;
`endif
    rise = lvl && !m_lvl_prev;
    e_cap_valid = 1'b0;
    e_timeout = 1'b0;
    e_step_valid = 1'b0;
    if (rise) begin
      if (armed) begin
        e_cap_high   = 16'(fall_t - rise_t);
        e_cap_period = 16'(now - rise_t);
        e_cap_valid  = 1'b1;
      end
      armed = 1;
      rise_t = now;
    end else if (armed && (now - rise_t == TIMEOUT)) begin
      e_timeout = 1'b1;
      e_stuck = lvl;
      armed = 0;
    end
    if (!lvl && m_lvl_prev) fall_t = now;
    if (se) begin
      e_on_sum = 16'((on_acc + lvl > CNT_MAX) ? CNT_MAX : on_acc + lvl);
      e_pulses = 8'((pulse_acc + rise > 255) ? 255 : pulse_acc + rise);
      e_step_valid = 1'b1;
      on_acc = 0;
      pulse_acc = 0;
    end else begin
      on_acc = (on_acc + lvl > CNT_MAX) ? CNT_MAX : on_acc + lvl;
      pulse_acc = (pulse_acc + rise > 255) ? 255 : pulse_acc + rise;
    end
    m_lvl_prev = lvl;
  endtask

  task automatic check_all();
    logic [59:0] act, exp;
    act = {cap_high, cap_period, cap_valid, step_on_sum, step_pulses, step_valid, timeout, stuck_level};
    exp = {e_cap_high, e_cap_period, e_cap_valid, e_on_sum, e_pulses, e_step_valid, e_timeout, e_stuck};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL outputs t=%0t act=%h exp=%h", $time, act, exp);
    end
    cnt_cap += cap_valid;
    cnt_tmo += timeout;
  endtask

  task automatic check_lit(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Inputs change just after the mid-cycle compare, well away from the falling edge.
  task automatic tick(input logic p, input logic se);
    pwm_in = p;
    step_end = se;
    @(negedge clk);
    model_edge(p, se);
    @(posedge clk);
    check_all();
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo, input bit end_step);
    for (int unsigned i = 0; i < hi; i++) tick(1'b1, 1'b0);
    for (int unsigned i = 0; i < lo; i++) tick(1'b0, (end_step && i == lo - 1));
  endtask

  task automatic do_reset();
    pwm_in = 1'b0;
    step_end = 1'b0;
    nRst = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      @(posedge clk);
      check_all();
    end
    check_lit("reset_cap_high", cap_high, 0);
    check_lit("reset_cap_period", cap_period, 0);
    check_lit("reset_step_on_sum", step_on_sum, 0);
    check_lit("reset_strobes", {cap_valid, step_valid, timeout, stuck_level}, 0);
    nRst = 1'b1;
  endtask

  initial begin
    now = 0;
    @(posedge clk);
    do_reset();

    // three 32/480 pulses closing one commutation step
    tick(1'b0, 1'b1);
    cnt_cap = 0;
    repeat (2) pulse(32, 480, 0);
    pulse(32, 480, 1);
    check_lit("step_valid", step_valid, 1);
    check_lit("step_on_sum_96", step_on_sum, 96);
    check_lit("step_pulses_3", step_pulses, 3);
    check_lit("cap_high_32", cap_high, 32);
    check_lit("cap_period_512", cap_period, 512);
    check_lit("cap_valid_count_3pulses", cnt_cap, 2);

    // 2-cycle glitch in a low phase, then a normal pulse
    cnt_cap = 0;
    pulse(2, 200, 0);
    pulse(32, 480, 0);
`ifdef M3_PWM_CAP_DEGLITCH_EN
    check_lit("glitch_cap_valid_count", cnt_cap, 1);
    check_lit("glitch_cap_high", cap_high, 32);
    check_lit("glitch_cap_period", cap_period, 714);
`else
    check_lit("glitch_cap_valid_count", cnt_cap, 2);
    check_lit("glitch_cap_high", cap_high, 2);
    check_lit("glitch_cap_period", cap_period, 202);
`endif

    // held low after a pulse
    cnt_tmo = 0;
    pulse(32, 1100, 0);
    check_lit("timeout_low_count", cnt_tmo, 1);
    check_lit("stuck_level_low", stuck_level, 0);
    check_lit("cap_high_kept", cap_high, 32);
    check_lit("cap_period_kept", cap_period, 512);

    // held high through a 70000-cycle step
    cnt_tmo = 0;
    tick(1'b1, 1'b1);
    repeat (70000) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check_lit("step_on_sum_sat", step_on_sum, 16'hFFFF);
    check_lit("timeout_high_count", cnt_tmo, 1);
    check_lit("stuck_level_high", stuck_level, 1);

    // reset in the middle of a high phase
    repeat (50) tick(1'b0, 1'b0);
    repeat (10) tick(1'b1, 1'b0);
    do_reset();
    cnt_cap = 0;
    pulse(32, 480, 0);
    check_lit("post_reset_first_rise", cnt_cap, 0);
    pulse(32, 480, 0);
    check_lit("post_reset_second_rise", cnt_cap, 1);
    check_lit("post_reset_cap_high", cap_high, 32);
    check_lit("post_reset_cap_period", cap_period, 512);

    // randomized pulse train with occasional stuck-low gaps and random step ends
    for (int i = 0; i < 25; i++) begin
      int unsigned h, l;
      h = $urandom_range(60, 1);
      l = ($urandom_range(7, 0) == 0) ? $urandom_range(1100, 1020) : $urandom_range(500, 1);
      for (int unsigned j = 0; j < h; j++) tick(1'b1, ($urandom_range(299, 0) == 0));
      for (int unsigned j = 0; j < l; j++) tick(1'b0, ($urandom_range(299, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
